// File: rtl/shift_pkg.sv
// Shared constants for the sequential RV32 shifter: operand/shamt widths,
// operation encodings and FSM state encodings.
package shift_pkg;

   localparam int XLEN = 32;
   localparam int SHW  = 5;

   typedef logic [1:0] sh_op_t;

   localparam sh_op_t SH_OP_SLL = 2'b00;
   localparam sh_op_t SH_OP_SRL = 2'b01;
   localparam sh_op_t SH_OP_RSV = 2'b10;
   localparam sh_op_t SH_OP_SRA = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step_32.sv
// One combinational shift step of the sequential shifter; SRA fill comes
// from the sign bit latched at accept, not from the partially shifted data.
module shift_step_32
   import shift_pkg::*;
(
   input  logic [XLEN-1:0] data,
   input  sh_op_t          op,
   input  logic [SHW-1:0]  amt,
   input  logic            sign,
   output logic [XLEN-1:0] data_nxt
);

   logic [XLEN-1:0] fill_mask;

   always_comb begin
      fill_mask = ~({XLEN{1'b1}} >> amt);
      case (op)
         SH_OP_SLL: data_nxt = data << amt;
         SH_OP_SRL: data_nxt = data >> amt;
         SH_OP_SRA: data_nxt = (data >> amt) | (fill_mask & {XLEN{sign}});
         default:   data_nxt = data;
      endcase
   end

endmodule

// File: rtl/shift_seq_32.sv
// Multi-cycle 32-bit SLL/SRL/SRA unit with valid/ready on both sides.
// Define SHIFT_SEQ_LOG_STEP_EN for 16/8/4/2/1 stepping instead of 8/1.
module shift_seq_32
   import shift_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_op,
   input  logic [XLEN-1:0] in_din,
   input  logic [XLEN-1:0] in_shift,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_dout
);

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] data_q, data_d;
   sh_op_t          op_q, op_d;
   logic [SHW-1:0]  cnt_q, cnt_d;
   logic            sign_q, sign_d;
   logic [SHW-1:0]  step;
   logic [XLEN-1:0] step_data;
   logic            unused_shift_hi;

   assign unused_shift_hi = ^in_shift[XLEN-1:SHW];

`ifdef SHIFT_SEQ_LOG_STEP_EN
   // Largest power of two still contained in the remaining count.
   always_comb begin
      if (cnt_q[4])      step = 5'd16;
      else if (cnt_q[3]) step = 5'd8;
      else if (cnt_q[2]) step = 5'd4;
      else if (cnt_q[1]) step = 5'd2;
      else               step = 5'd1;
   end
`else
   assign step = (cnt_q >= 5'd8) ? 5'd8 : 5'd1;
`endif

   shift_step_32 u_step (
      .data     (data_q),
      .op       (op_q),
      .amt      (step),
      .sign     (sign_q),
      .data_nxt (step_data)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               data_d = in_din;
               op_d   = in_op;
               cnt_d  = in_shift[SHW-1:0];
               sign_d = in_din[XLEN-1];
               if (in_shift[SHW-1:0] == '0 || in_op == SH_OP_RSV) state_d = ST_DONE;
               else                                             state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            data_d = step_data;
            cnt_d  = cnt_q - step;
            if (cnt_d == '0) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         op_q    <= SH_OP_SLL;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_dout  = data_q;

endmodule
